// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions: datapath widths, special instruction words and the
// fetch-unit state encoding.
package fetch_stage_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]         HALT_OP   = 5'b10000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr,
                                     input logic [4:0]         opcode);
        return instr[15:11] == opcode;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signals between the fetch stage and its neighbours: redirect/stall control,
// instruction memory, and the IF/ID register outputs.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic               stall;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;
    logic [ADDR_W-1:0]  imem_address;
    logic [INSTR_W-1:0] imem_data;
    logic               if_id_valid;
    logic [INSTR_W-1:0] if_id_instr;
    logic [ADDR_W-1:0]  if_id_pc_next;
    logic               halted;
    logic               fetch_fault;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_data,
        output imem_address, if_id_valid, if_id_instr, if_id_pc_next,
               halted, fetch_fault
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_data,
        input  imem_address, if_id_valid, if_id_instr, if_id_pc_next,
               halted, fetch_fault
    );

endinterface

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: loads a fetched word, inserts a bubble, or holds.
module if_id_register
    import fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc_next,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_next
);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            instr   <= NOP_WORD;
            pc_next <= '0;
        end else if (bubble) begin
            valid <= 1'b0;
            instr <= NOP_WORD;
        end else if (load) begin
            valid   <= 1'b1;
            instr   <= load_instr;
            pc_next <= load_pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and run/halt/fault state, drives the
// instruction memory address and fills the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC    = 16'h0000,
    parameter int unsigned        MEM_DEPTH   = 256,
    parameter logic [INSTR_W-1:0] NOP_WORD    = NOP_INSTR,
    parameter logic [4:0]         HALT_OPCODE = HALT_OP
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    logic [ADDR_W-1:0] pc;
    fetch_state_e      state;
    logic              halted_q;
    logic              fault_q;
    logic              pc_out_of_range;
    logic              word_is_halt;
    logic              ifid_load;
    logic              ifid_bubble;

    assign bus.imem_address = pc;
    assign bus.halted       = halted_q;
    assign bus.fetch_fault  = fault_q;

    assign pc_out_of_range = 32'(pc) >= MEM_DEPTH;
    assign word_is_halt    = is_halt(bus.imem_data, HALT_OPCODE);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (bus.redirect_valid) begin
            ifid_bubble = 1'b1;
        end else if (!bus.stall) begin
            if (state == ST_RUN && !pc_out_of_range) begin
                ifid_load = 1'b1;
            end else begin
                ifid_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            state    <= ST_RUN;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (bus.redirect_valid) begin
            // A redirect means any HALT or faulting fetch was on the wrong path.
            pc       <= bus.redirect_target;
            state    <= ST_RUN;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (!bus.stall && state == ST_RUN) begin
            if (pc_out_of_range) begin
                state   <= ST_FAULT;
                fault_q <= 1'b1;
            end else if (word_is_halt) begin
                // PC parks on the HALT word; it is delivered once, then bubbles.
                state    <= ST_HALT;
                halted_q <= 1'b1;
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

    if_id_register #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk          (clk),
        .rst          (rst),
        .load         (ifid_load),
        .bubble       (ifid_bubble),
        .load_instr   (bus.imem_data),
        .load_pc_next (pc + 1'b1),
        .valid        (bus.if_id_valid),
        .instr        (bus.if_id_instr),
        .pc_next      (bus.if_id_pc_next)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit word-addressed CPU. It sits between the PC-redirect logic (branch/jump resolution in later stages) and the combinational instruction memory.
- Owns the program counter and drives the memory address combinationally from it. Captures the returned word into the IF/ID pipeline register.
- Handles decode-stage stalls, redirect-driven flushes, HALT-opcode detection and out-of-range fetch faults.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MEM_DEPTH, 256, number of valid instruction words; any PC >= MEM_DEPTH is a fetch fault.
- NOP_WORD, 16'h0800, instruction word emitted on IF/ID when the slot is a bubble.
- HALT_OPCODE, 5'b10000, value of instr[15:11] that marks a HALT instruction.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode cannot accept; hold PC and IF/ID.
- redirect_valid  in  1  later stage resolved a taken branch/jump this cycle.
- redirect_target  in  16  new PC, in word address units.
- imem_address  out  16  combinational copy of the PC, feeding instruction memory.
- imem_data  in  16  combinational read data for imem_address.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  16  registered instruction word.
- if_id_pc_next  out  16  registered PC+1 of that instruction, for link and branch base.
- halted  out  1  unit is in the HALT state.
- fetch_fault  out  1  unit is in the FAULT state.

Behaviour:
- Reset (rst=1 at an edge, overrides everything):
  - pc=RESET_PC, state=RUN.
  - if_id_valid=0, if_id_instr=NOP_WORD, if_id_pc_next=0.
  - halted=0, fetch_fault=0.
- States: RUN, HALT, FAULT. halted=(state==HALT) and fetch_fault=(state==FAULT), both registered.
- imem_address=pc at all times, zero latency. imem_data is sampled in the same cycle.
- Per-edge priority: rst > redirect_valid > stall > normal.
- redirect_valid=1, in any state and regardless of stall:
  - pc<=redirect_target, state<=RUN.
  - IF/ID <= bubble (valid=0, instr=NOP_WORD).
  - The word currently on imem_data is discarded.
  - Redirect out of HALT/FAULT is legal: the HALT or faulting fetch was on the wrong path.
- stall=1, no redirect: pc, IF/ID and state all hold.
- RUN, normal:
  - Fault check first: if pc >= MEM_DEPTH, state<=FAULT, IF/ID<=bubble, pc holds.
  - Otherwise IF/ID <= {1, imem_data, pc+1}.
  - If imem_data[15:11]==HALT_OPCODE: state<=HALT and pc holds, so the HALT word itself is delivered once.
  - Else pc<=pc+1, wrapping modulo 2^16 (16'hFFFF -> 16'h0000; the fault check catches it first when MEM_DEPTH<65536).
- HALT or FAULT, normal: pc holds, IF/ID<=bubble every cycle. Exit only via redirect or rst.
- Throughput: one instruction per cycle in RUN with no stall.
- Redirect penalty: exactly one bubble, for the fetch cycle of the target.
- Mid-operation rst behaves exactly like power-on reset; no partial state is kept.

Decomposition:
- Shared CPU package holds:
  - the instruction width (16) and address width (16);
  - NOP_WORD and the HALT opcode;
  - the state enum {RUN, HALT, FAULT}.
- One natural sub-module: if_id_register. It holds the valid/instr/pc_next register with load, hold and bubble controls. The PC and state machine stay in fetch_stage.
- Instruction memory is instantiated outside this block and connected through imem_address/imem_data.

Test Plan:
1. Reset then free-run, memory words 0..3 = A,B,C,D (none HALT), no stall:
   - first edge after reset: if_id_valid=1, instr=A, pc_next=1;
   - following edges: B/2, C/3, D/4.
2. Stall held for 3 cycles after B is in IF/ID:
   - IF/ID stays B/2 and imem_address stays 2 for all 3 cycles;
   - C is delivered on the first edge after stall drops.
3. redirect_valid with target 16'h000A while IF/ID holds C:
   - next edge: if_id_valid=0, instr=NOP_WORD, imem_address=10;
   - following edge: word[10] with pc_next=11.
4. Word at address 5 = 16'h8000 (HALT):
   - IF/ID delivers 16'h8000 once, then halted=1, if_id_valid=0 and imem_address=5 for 10+ cycles;
   - redirect to 16'h0000 clears halted and fetch resumes at 0.
5. Redirect to 16'h0100 with MEM_DEPTH=256:
   - after the bubble, fetch_fault=1, if_id_valid=0, imem_address=256;
   - assert rst for one edge: pc=0, fetch_fault=0.
6. Stall=1 and redirect_valid=1 on the same edge:
   - redirect wins: PC loaded with the target and the IF/ID slot is a bubble.
